serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
Parametrised bit-serial adder/subtractor. It is the sequential, width-generic successor to the team's 4-bit combinational ripple adder. One full-adder cell and a carry flip-flop process one bit per clock, LSB first, under a start/busy/done handshake. It sits between switch/register inputs and LED/display or counter logic, wherever area matters more than latency.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..32.
CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
Clock  input  1  rising-edge clock.
Resetn  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when not busy.
A  input  WIDTH  operand A; captured on the accepting edge.
B  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge; ignored when sub=1.
sub  input  1  1 = A-B (B inverted, initial carry 1); captured on the accepting edge.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when the result becomes valid.
sum  output  WIDTH  result; updated only at completion.
cout  output  1  final carry-out. In sub mode, 1 = no borrow.
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (Resetn=0, asynchronous): state IDLE; busy, done, sum, cout, overflow all 0; internal shift registers, carry and counter cleared. Reset during RUN aborts the operation with no partial result.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge (the accepting edge):
  - Load a_sh=A and b_sh=(sub ? ~B : B).
  - Set carry = sub ? 1 : cin and counter=0.
  - Go to RUN.
  - Inputs A, B, cin and sub may change freely afterwards.
- RUN, each edge:
  - Compute s = a_sh[0]^b_sh[0]^carry.
  - Update carry to the majority of a_sh[0], b_sh[0] and carry.
  - Shift a_sh and b_sh right; shift s into the MSB of the internal result register.
  - Increment the counter.
  - On the edge where counter==WIDTH-2 is processed, also latch carry-in-to-MSB.
- RUN, edge where counter==WIDTH-1:
  - Final bit is processed.
  - sum <= completed result; cout <= new carry; overflow <= msb_carry_in ^ new carry.
  - Go to DONE.
- DONE: done=1 for exactly that one cycle. Without start, go to IDLE next edge.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy=1 exactly in state RUN.
- start while busy is ignored, with no queuing and no error.
- start during the DONE cycle is accepted: DONE goes directly to RUN, done still pulses, and busy rises next cycle.
- sum, cout and overflow hold their last value until the next completion. They are not cleared on start.
- Arithmetic is modulo 2^WIDTH. No sign extension. Carry and overflow are reported only through cout and overflow.

Test Plan:
1. WIDTH=4: A=7, B=9, cin=0, sub=0, start for one cycle → busy high 4 cycles, then done pulse; sum=0, cout=1, overflow=0.
2. WIDTH=4: A=5, B=3, cin=1, sub=0 → sum=9, cout=0, overflow=1 (signed 5+3+1 exceeds 7).
3. WIDTH=4: A=3, B=5, sub=1, cin=1 (ignored) → sum=14, cout=0 (borrow), overflow=0. Then A=5, B=3, sub=1 → sum=2, cout=1, overflow=0.
4. WIDTH=8: A=0xFF, B=0x01, cin=0 → done 8 cycles after the accepting edge; sum=0x00, cout=1, overflow=0. Then A=0x7F, B=0x01 → sum=0x80, overflow=1, cout=0.
5. WIDTH=4 handshake:
   - Hold start high and change A/B while busy → result reflects only the first captured operands.
   - start asserted in the DONE cycle → second operation accepted with no idle gap.
   - sum stays stable between done pulses.
6. WIDTH=4: assert Resetn=0 asynchronously two cycles into RUN → busy, done, sum, cout and overflow go to 0 immediately. After release, a new start (A=1, B=1) yields sum=2 with correct latency.

Source files
------------

// File: rtl/serial_adder_n.sv
// serial_adder_n: bit-serial adder/subtractor, one bit per clock, LSB first.
// A single full-adder cell plus a carry flop walks through WIDTH bits under a
// start/busy/done handshake. Results appear on sum/cout/overflow only at
// completion and hold until the next completion.
module serial_adder_n #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENUL = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             msb_cin;

  logic             load;
  logic             last;
  logic             s_bit;
  logic             carry_n;

  assign last = (cnt == LAST);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; start is honoured in IDLE and DONE only.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The single full-adder cell operating on the current LSBs.
  always_comb begin
    s_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    carry_n = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // Operand capture, serial shifting and result publication.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      msb_cin  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // Subtraction is A + ~B + 1, so cin is irrelevant when sub is set.
      a_sh  <= A;
      b_sh  <= sub ? ~B : B;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= {s_bit, res_sh[WIDTH-1:1]};
      carry  <= carry_n;
      cnt    <= cnt + CW'(1);
      if (cnt == PENUL) begin
        msb_cin <= carry_n;
      end
      if (last) begin
        sum      <= {s_bit, res_sh[WIDTH-1:1]};
        cout     <= carry_n;
        overflow <= msb_cin ^ carry_n;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: a 4-bit and an 8-bit instance driven side by side,
// checked every cycle against an arithmetic model of the handshake, with
// literal expectations pinned to the directed operations.
module tb_serial_adder_n;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ov4;
  logic [3:0] sum4;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ov8;
  logic [7:0] sum8;

  int tests = 0;
  int fails = 0;

  serial_adder_n #(.WIDTH(4)) u_w4 (
    .Clock(clk), .Resetn(rst_n), .start(start4), .A(a4), .B(b4),
    .cin(cin4), .sub(sub4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .overflow(ov4)
  );

  serial_adder_n #(.WIDTH(8)) u_w8 (
    .Clock(clk), .Resetn(rst_n), .start(start8), .A(a8), .B(b8),
    .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .overflow(ov8)
  );

  always #5 clk = ~clk;

  // Model: cycles of work left, published result, pending result.
  int unsigned m_left[2];
  bit          m_done[2];
  logic [31:0] m_sum[2];
  bit          m_cout[2];
  bit          m_ov[2];
  logic [31:0] p_sum[2];
  bit          p_cout[2];
  bit          p_ov[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      longint unsigned ia, ib, bb, full, mask;
      bit ist, ic, isb, nd, sa, sb, ss;
      int w;
      if (i == 0) begin
        w = 4; ia = 64'(a4); ib = 64'(b4); ist = start4; ic = cin4; isb = sub4;
      end else begin
        w = 8; ia = 64'(a8); ib = 64'(b8); ist = start8; ic = cin8; isb = sub8;
      end
      nd = 1'b0;
      if (!rst_n) begin
        m_left[i] = 0; m_done[i] = 1'b0;
        m_sum[i] = '0; m_cout[i] = 1'b0; m_ov[i] = 1'b0;
      end else begin
        if (m_left[i] != 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_sum[i]  = p_sum[i];
            m_cout[i] = p_cout[i];
            m_ov[i]   = p_ov[i];
            nd        = 1'b1;
          end
        end else if (ist) begin
          mask = (64'd1 << w) - 64'd1;
          bb   = (isb ? ~ib : ib) & mask;
          full = ia + bb + (isb ? 64'd1 : 64'(ic));
          p_sum[i]  = 32'(full & mask);
          p_cout[i] = bit'((full >> w) & 64'd1);
          sa = bit'((ia >> (w - 1)) & 64'd1);
          sb = bit'((bb >> (w - 1)) & 64'd1);
          ss = bit'(((full & mask) >> (w - 1)) & 64'd1);
          p_ov[i]   = (sa == sb) && (ss != sa);
          m_left[i] = w;
        end
        m_done[i] = nd;
      end
    end
  end

  typedef struct {
    bit          chk;
    logic [31:0] s;
    bit          c;
    bit          o;
  } pin_t;

  pin_t        pin4[$];
  pin_t        pin8[$];
  int unsigned ri4 = 0;
  int unsigned ri8 = 0;
  bit          finish_req = 1'b0;
  bit          final_chk  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, and just after an asynchronous reset.
  always begin
    pin_t p;
    @(negedge clk or negedge rst_n);
    #1;
    chk("w4_busy", 32'(busy4), 32'(m_left[0] != 0));
    chk("w4_done", 32'(done4), 32'(m_done[0]));
    chk("w4_sum",  32'(sum4),  m_sum[0]);
    chk("w4_cout", 32'(cout4), 32'(m_cout[0]));
    chk("w4_ovf",  32'(ov4),   32'(m_ov[0]));
    chk("w8_busy", 32'(busy8), 32'(m_left[1] != 0));
    chk("w8_done", 32'(done8), 32'(m_done[1]));
    chk("w8_sum",  32'(sum8),  m_sum[1]);
    chk("w8_cout", 32'(cout8), 32'(m_cout[1]));
    chk("w8_ovf",  32'(ov8),   32'(m_ov[1]));
    if (m_done[0] && ri4 < pin4.size()) begin
      p = pin4[ri4];
      ri4++;
      if (p.chk) begin
        chk("pin4_sum",   32'(sum4),       p.s);
        chk("pin4_cout",  32'(cout4),      32'(p.c));
        chk("pin4_ovf",   32'(ov4),        32'(p.o));
        chk("pin4_model", {m_sum[0][29:0], m_cout[0], m_ov[0]}, {p.s[29:0], p.c, p.o});
      end
    end
    if (m_done[1] && ri8 < pin8.size()) begin
      p = pin8[ri8];
      ri8++;
      if (p.chk) begin
        chk("pin8_sum",   32'(sum8),       p.s);
        chk("pin8_cout",  32'(cout8),      32'(p.c));
        chk("pin8_ovf",   32'(ov8),        32'(p.o));
        chk("pin8_model", {m_sum[1][29:0], m_cout[1], m_ov[1]}, {p.s[29:0], p.c, p.o});
      end
    end
    if (finish_req && !final_chk) begin
      chk("pins4_consumed", 32'(ri4), 32'(pin4.size()));
      chk("pins8_consumed", 32'(ri8), 32'(pin8.size()));
      final_chk = 1'b1;
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic s,
                     input logic [3:0] es, input logic ec, input logic eo);
    pin4.push_back('{1'b1, 32'(es), ec, eo});
    @(posedge clk); #1;
    a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo);
    pin8.push_back('{1'b1, 32'(es), ec, eo});
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    repeat (9) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    op4(4'd7, 4'd9, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
    op4(4'd5, 4'd3, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1);
    op4(4'd3, 4'd5, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0);
    op4(4'd5, 4'd3, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // start held through RUN with churning operands, then re-accepted in DONE
    pin4.push_back('{1'b1, 32'd13, 1'b0, 1'b1});
    pin4.push_back('{1'b1, 32'd5,  1'b0, 1'b0});
    @(posedge clk); #1;
    a4 = 4'd6; b4 = 4'd7; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
    end
    @(posedge clk); #1;
    a4 = 4'd2; b4 = 4'd3; cin4 = 1'b0; sub4 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // reset two cycles into RUN, then a fresh operation
    a4 = 4'd6; b4 = 4'd1; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    op4(4'd1, 4'd1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);

    // randomized traffic on both widths
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a4 = '1;
      if ($urandom_range(0, 7) == 0) b8 = '1;
      start4 = ($urandom_range(0, 2) == 0);
      start8 = ($urandom_range(0, 3) == 0);
    end
    start4 = 1'b0;
    start8 = 1'b0;
    repeat (15) @(posedge clk);

    finish_req = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
